// File: rtl/mem_read_arbiter_if.sv
// Read channel bundle: an address request path and a data return path,
// each with its own valid/ready handshake.
interface mem_read_arbiter_if #(
   parameter int BUS_WIDTH = 32
);
   logic                 addr_valid;
   logic [BUS_WIDTH-1:0] addr;
   logic                 addr_ready;
   logic                 data_valid;
   logic [BUS_WIDTH-1:0] data;
   logic                 data_ready;

   // The master issues addresses and consumes data; the slave does the reverse.
   modport master (
      output addr_valid, addr, data_ready,
      input  addr_ready, data_valid, data
   );

   modport slave (
      input  addr_valid, addr, data_ready,
      output addr_ready, data_valid, data
   );
endinterface

// File: rtl/mem_read_arbiter.sv
// Two-requester arbiter (instruction/data) in front of a single memory read
// port. One transaction in flight; round-robin or fixed data-first priority.
module mem_read_arbiter #(
   parameter int BUS_WIDTH = 32,
   parameter bit RR_EN     = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   mem_read_arbiter_if.slave  ir,
   mem_read_arbiter_if.slave  dr,
   mem_read_arbiter_if.master m
);

   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
   typedef enum logic {OWN_IR, OWN_DR} owner_t;

   state_t               state_q, state_d;
   owner_t               owner_q, last_q, grant;
   logic [BUS_WIDTH-1:0] addr_q;
   logic                 addr_valid_q;
   logic                 idle, in_data, addr_hs, data_hs;

   assign idle    = (state_q == IDLE);
   assign in_data = (state_q == DATA);

   // NOTE: every signal assigned in always_comb gets a default first so no
   // path leaves it unassigned, which would infer a latch.
   always_comb begin
      grant = OWN_IR;
      if (RR_EN) begin
         if (ir.addr_valid && dr.addr_valid)
            grant = (last_q == OWN_IR) ? OWN_DR : OWN_IR;
         else if (dr.addr_valid)
            grant = OWN_DR;
      end else if (dr.addr_valid) begin
         grant = OWN_DR;
      end
   end

   // Address readies are gated by rst so nothing is accepted during reset.
   assign ir.addr_ready = rst && idle && (grant == OWN_IR) && ir.addr_valid;
   assign dr.addr_ready = rst && idle && (grant == OWN_DR) && dr.addr_valid;

   assign addr_hs = ir.addr_ready || dr.addr_ready;
   assign data_hs = in_data && m.data_valid && m.data_ready;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (addr_hs)      state_d = ADDR;
         ADDR:    if (m.addr_ready) state_d = DATA;
         DATA:    if (data_hs)      state_d = IDLE;
         default:                   state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_q       <= '0;
         addr_valid_q <= 1'b0;
         owner_q      <= OWN_IR;
         last_q       <= OWN_DR;
      end else begin
         if (addr_hs) begin
            addr_q       <= (grant == OWN_DR) ? dr.addr : ir.addr;
            owner_q      <= grant;
            addr_valid_q <= 1'b1;
         end else if ((state_q == ADDR) && m.addr_ready) begin
            addr_valid_q <= 1'b0;
         end
         if (data_hs) last_q <= owner_q;
      end
   end

   assign m.addr_valid = addr_valid_q;
   assign m.addr       = addr_q;

   // Return path is a pure combinational pass-through while in DATA.
   assign ir.data       = m.data;
   assign dr.data       = m.data;
   assign ir.data_valid = in_data && (owner_q == OWN_IR) && m.data_valid;
   assign dr.data_valid = in_data && (owner_q == OWN_DR) && m.data_valid;
   assign m.data_ready  = in_data && ((owner_q == OWN_DR) ? dr.data_ready : ir.data_ready);

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Scoreboard bench: a round-robin instance driven by directed vectors and a
// fixed-priority instance running continuously with both requesters valid.
module tb_mem_read_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   mem_read_arbiter_if #(.BUS_WIDTH(32)) ia(), da(), ma();
   mem_read_arbiter_if #(.BUS_WIDTH(32)) ib(), db(), mb();

   mem_read_arbiter #(.BUS_WIDTH(32), .RR_EN(1'b1)) dut_rr (
      .clk(clk), .rst(rst), .ir(ia), .dr(da), .m(ma)
   );

   mem_read_arbiter #(.BUS_WIDTH(32), .RR_EN(1'b0)) dut_fp (
      .clk(clk), .rst(rst), .ir(ib), .dr(db), .m(mb)
   );

   int errors = 0;
   int checks = 0;
   int b_count = 0;
   bit b_ir_ready_seen = 1'b0;
   bit b_ir_data_seen  = 1'b0;

   logic [31:0] exp_maddr[$];
   logic [31:0] exp_ir[$];
   logic [31:0] exp_dr[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s: got unexpected or missing event, expected none", name);
   endtask

   // Monitor for the round-robin instance: pops expectations on handshakes.
   always @(negedge clk) begin
      if (rst) begin
         if (ma.addr_valid && ma.addr_ready) begin
            if (exp_maddr.size() == 0) fail_now("rr_m_addr_unexpected");
            else check("rr_m_addr", ma.addr, exp_maddr.pop_front());
         end
         if (ia.data_valid) begin
            if (exp_ir.size() == 0) fail_now("rr_ir_data_valid_unexpected");
            else if (ia.data_ready) check("rr_ir_data", ia.data, exp_ir.pop_front());
         end
         if (da.data_valid) begin
            if (exp_dr.size() == 0) fail_now("rr_dr_data_valid_unexpected");
            else if (da.data_ready) check("rr_dr_data", da.data, exp_dr.pop_front());
         end
      end
   end

   // Monitor for the fixed-priority instance.
   always @(negedge clk) begin
      if (rst && mb.addr_valid && mb.addr_ready) begin
         check("fp_m_addr_is_dr", mb.addr, 32'h0000_020B);
         b_count++;
      end
      if (ib.addr_ready) b_ir_ready_seen = 1'b1;
      if (ib.data_valid) b_ir_data_seen  = 1'b1;
   end

   initial begin
      ib.addr_valid = 1'b1; ib.addr = 32'h0000_010B; ib.data_ready = 1'b1;
      db.addr_valid = 1'b1; db.addr = 32'h0000_020B; db.data_ready = 1'b1;
      mb.addr_ready = 1'b1; mb.data_valid = 1'b1;    mb.data = 32'h0B0B_0B0B;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic issue(input bit is_dr, input logic [31:0] addr);
      bit rdy;
      if (is_dr) begin da.addr_valid = 1'b1; da.addr = addr; end
      else       begin ia.addr_valid = 1'b1; ia.addr = addr; end
      for (int i = 0; i < 40; i++) begin
         #1;
         rdy = is_dr ? da.addr_ready : ia.addr_ready;
         if (rdy) begin
            @(posedge clk); #1;
            if (is_dr) da.addr_valid = 1'b0; else ia.addr_valid = 1'b0;
            check("m_addr_valid_next_cycle", {31'b0, ma.addr_valid}, 32'd1);
            check("m_addr_next_cycle", ma.addr, addr);
            return;
         end
         @(posedge clk);
      end
      if (is_dr) da.addr_valid = 1'b0; else ia.addr_valid = 1'b0;
      fail_now("issue_timeout");
   endtask

   task automatic mem_addr_phase(input logic [31:0] exp, input int stall);
      for (int i = 0; i < 20 && !ma.addr_valid; i++) begin
         @(posedge clk); #1;
      end
      check("m_addr_valid_seen", {31'b0, ma.addr_valid}, 32'd1);
      for (int i = 0; i < stall; i++) begin
         check("stall_m_addr_valid", {31'b0, ma.addr_valid}, 32'd1);
         check("stall_m_addr", ma.addr, exp);
         @(posedge clk); #1;
      end
      ma.addr_ready = 1'b1;
      @(posedge clk); #1;
      ma.addr_ready = 1'b0;
   endtask

   task automatic mem_data_phase(input logic [31:0] data, input int lat, input int hold);
      bit done = 1'b0;
      repeat (lat) begin @(posedge clk); #1; end
      ma.data_valid = 1'b1;
      ma.data       = data;
      for (int i = 0; i < hold; i++) begin
         #1;
         check("bp_m_data_ready_low", {31'b0, ma.data_ready}, 32'd0);
         @(posedge clk); #1;
      end
      ia.data_ready = 1'b1;
      da.data_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         #1;
         if (ma.data_ready) begin
            @(posedge clk); #1;
            done = 1'b1;
            break;
         end
         @(posedge clk);
      end
      if (!done) fail_now("data_handshake_timeout");
      ma.data_valid = 1'b0;
   endtask

   initial begin
      ia.addr_valid = 1'b0; ia.addr = '0; ia.data_ready = 1'b1;
      da.addr_valid = 1'b0; da.addr = '0; da.data_ready = 1'b1;
      ma.addr_ready = 1'b0; ma.data_valid = 1'b0; ma.data = '0;

      // Reset state, with both requesters already asserting.
      repeat (3) @(posedge clk);
      #1;
      ia.addr_valid = 1'b1; ia.addr = 32'h10;
      da.addr_valid = 1'b1; da.addr = 32'h20;
      #1;
      check("rst_m_addr_valid", {31'b0, ma.addr_valid}, 32'd0);
      check("rst_m_addr", ma.addr, 32'd0);
      check("rst_ir_addr_ready", {31'b0, ia.addr_ready}, 32'd0);
      check("rst_dr_addr_ready", {31'b0, da.addr_ready}, 32'd0);
      check("rst_m_data_ready", {31'b0, ma.data_ready}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;

      // Round-robin tie from reset: ir, dr, ir.
      exp_maddr.push_back(32'h10); exp_ir.push_back(32'h0000_1010);
      exp_maddr.push_back(32'h20); exp_dr.push_back(32'h0000_2020);
      exp_maddr.push_back(32'h10); exp_ir.push_back(32'h0000_1011);
      mem_addr_phase(32'h10, 0); mem_data_phase(32'h0000_1010, 1, 0);
      mem_addr_phase(32'h20, 0); mem_data_phase(32'h0000_2020, 1, 0);
      mem_addr_phase(32'h10, 0); mem_data_phase(32'h0000_1011, 1, 0);
      ia.addr_valid = 1'b0;
      da.addr_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Single instruction read.
      exp_maddr.push_back(32'h100); exp_ir.push_back(32'hDEAD_BEEF);
      fork
         issue(1'b0, 32'h100);
         begin mem_addr_phase(32'h100, 0); mem_data_phase(32'hDEAD_BEEF, 2, 0); end
      join

      // Backpressure on both address and data channels.
      da.data_ready = 1'b0;
      exp_maddr.push_back(32'h200); exp_dr.push_back(32'hCAFE_F00D);
      fork
         issue(1'b1, 32'h200);
         begin mem_addr_phase(32'h200, 5); mem_data_phase(32'hCAFE_F00D, 1, 3); end
      join

      // Stray memory data while idle.
      @(posedge clk); #1;
      ma.data_valid = 1'b1; ma.data = 32'h77;
      repeat (2) begin
         #1;
         check("stray_m_data_ready", {31'b0, ma.data_ready}, 32'd0);
         check("stray_ir_data_valid", {31'b0, ia.data_valid}, 32'd0);
         check("stray_dr_data_valid", {31'b0, da.data_valid}, 32'd0);
         @(posedge clk); #1;
      end
      ma.data_valid = 1'b0;

      // Reset while awaiting data abandons the transaction.
      exp_maddr.push_back(32'h300);
      fork
         issue(1'b1, 32'h300);
         mem_addr_phase(32'h300, 0);
      join
      #1; rst = 1'b0;
      #1;
      check("rst_data_m_addr_valid", {31'b0, ma.addr_valid}, 32'd0);
      check("rst_data_m_data_ready", {31'b0, ma.data_ready}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      ma.data_valid = 1'b1; ma.data = 32'h55;
      repeat (2) begin
         #1;
         check("abandon_m_data_ready", {31'b0, ma.data_ready}, 32'd0);
         check("abandon_ir_data_valid", {31'b0, ia.data_valid}, 32'd0);
         check("abandon_dr_data_valid", {31'b0, da.data_valid}, 32'd0);
         @(posedge clk); #1;
      end
      ma.data_valid = 1'b0;

      exp_maddr.push_back(32'h400); exp_ir.push_back(32'h1234_5678);
      fork
         issue(1'b0, 32'h400);
         begin mem_addr_phase(32'h400, 0); mem_data_phase(32'h1234_5678, 1, 0); end
      join

      repeat (5) @(posedge clk);
      #1;
      check("sb_m_addr_drained", exp_maddr.size(), 32'd0);
      check("sb_ir_drained", exp_ir.size(), 32'd0);
      check("sb_dr_drained", exp_dr.size(), 32'd0);
      check("fp_enough_transactions", {31'b0, (b_count >= 10)}, 32'd1);
      check("fp_ir_addr_ready_never", {31'b0, b_ir_ready_seen}, 32'd0);
      check("fp_ir_data_valid_never", {31'b0, b_ir_data_seen}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
